// File: rtl/shannon_whitaker_coeff_sequencer.sv
// Coefficient update sequencer for the systolic lowpass filter: shadow bank, one-per-cycle
// commit into the active DSP B-port bank, then output blanking while stale products flush.
module shannon_whitaker_coeff_sequencer #(
  parameter int unsigned NTAPS        = 8,
  parameter int unsigned COEFFBITS    = 18,
  parameter int unsigned FLUSH_CYCLES = 12,
  parameter logic [NTAPS*COEFFBITS-1:0] DEFAULT_COEFFS = {
    18'sd10342, -18'sd3216, 18'sd1672, -18'sd949,
    18'sd526,   -18'sd263,  18'sd105,  18'sd23
  }
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_i,
  input  logic [3:0]                   wr_addr_i,
  input  logic [COEFFBITS-1:0]         wr_dat_i,
  input  logic                         commit_i,
  output logic [NTAPS*COEFFBITS-1:0]   coeff_o,
  output logic [NTAPS-1:0]             coeff_ce_o,
  output logic                         valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         wr_err_o
);

  localparam int unsigned IdxW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NTAPS - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  state_e                              state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic                                pending_q, pending_d;

  logic [NTAPS-1:0][COEFFBITS-1:0]     shadow_q, active_q;

  logic                                valid_q, valid_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                wr_err_q, wr_err_d;
  logic [NTAPS-1:0]                    ce_q, ce_d;

  // State register; reset enters FLUSH so the pipeline fills before valid is raised.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFlush;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      ce_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      ce_q      <= ce_d;
    end
  end

  // Coefficient banks. LOAD copies the shadow value held at the start of the cycle, so a
  // same-cycle write to the slot being copied waits for the next commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= DEFAULT_COEFFS;
      active_q <= DEFAULT_COEFFS;
    end else begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        if (wr_i && (32'(wr_addr_i) == k)) begin
          shadow_q[k] <= wr_dat_i;
        end
      end
      if (state_q == StLoad) begin
        active_q[idx_q] <= shadow_q[idx_q];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (commit_i) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (commit_i) begin
          pending_d = 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFlush: begin
        if (commit_i) begin
          pending_d = 1'b1;
        end
        if (cnt_q == LastCnt) begin
          // A commit arriving in the final flush cycle is honoured, not dropped.
          if (pending_q || commit_i) begin
            state_d   = StLoad;
            idx_d     = '0;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StFlush;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // Output logic, decoded from the next state so every output is a flop.
  always_comb begin
    valid_d  = (state_d == StIdle);
    busy_d   = (state_d != StIdle);
    done_d   = (state_q == StFlush) && (state_d == StIdle);
    wr_err_d = wr_i && (32'(wr_addr_i) >= NTAPS);
    ce_d     = '0;
    if (state_d == StLoad) begin
      ce_d[idx_d] = 1'b1;
    end
  end

  assign coeff_o    = active_q;
  assign coeff_ce_o = ce_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wr_err_o   = wr_err_q;

endmodule

// File: tb/tb_shannon_whitaker_coeff_sequencer.sv
// Directed bench for shannon_whitaker_coeff_sequencer with hand-computed expectations.
module tb_shannon_whitaker_coeff_sequencer;

  localparam int unsigned NTAPS = 8;
  localparam int unsigned CB    = 18;
  localparam int unsigned FC    = 12;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  wr = 1'b0;
  logic [3:0]            wr_addr = '0;
  logic [CB-1:0]         wr_dat = '0;
  logic                  commit = 1'b0;
  logic [NTAPS*CB-1:0]   coeff;
  logic [NTAPS-1:0]      ce;
  logic                  valid;
  logic                  busy;
  logic                  done;
  logic                  wr_err;

  int n_cmp = 0;
  int n_bad = 0;
  int defs[NTAPS]  = '{23, 105, -263, 526, -949, 1672, -3216, 10342};
  int model[NTAPS];

  shannon_whitaker_coeff_sequencer #(
    .NTAPS       (NTAPS),
    .COEFFBITS   (CB),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_i      (wr),
    .wr_addr_i (wr_addr),
    .wr_dat_i  (wr_dat),
    .commit_i  (commit),
    .coeff_o   (coeff),
    .coeff_ce_o(ce),
    .valid_o   (valid),
    .busy_o    (busy),
    .done_o    (done),
    .wr_err_o  (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int slot(input int k);
    logic signed [CB-1:0] v;
    v = coeff[k*CB +: CB];
    return int'(v);
  endfunction

  // Advance one cycle; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    wr     = 1'b0;
    commit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < NTAPS; k++) begin
      check_eq($sformatf("%s slot%0d", tag, k), slot(k), model[k]);
    end
  endtask

  // Called in release cycle 0: blanking for FC cycles, then valid and done together.
  task automatic check_release(input string tag);
    check_eq({tag, " valid0"}, int'(valid), 0);
    check_eq({tag, " busy0"}, int'(busy), 1);
    check_eq({tag, " done0"}, int'(done), 0);
    check_eq({tag, " ce0"}, int'(ce), 0);
    check_eq({tag, " wr_err0"}, int'(wr_err), 0);
    for (int c = 0; c < FC; c++) begin
      check_eq($sformatf("%s blank c%0d", tag, c), int'(valid), 0);
      tick();
    end
    check_eq({tag, " valid@12"}, int'(valid), 1);
    check_eq({tag, " done@12"}, int'(done), 1);
    check_eq({tag, " busy@12"}, int'(busy), 0);
    tick();
    check_eq({tag, " done@13"}, int'(done), 0);
  endtask

  task automatic write_shadow(input int a, input int d);
    wr      = 1'b1;
    wr_addr = 4'(a);
    wr_dat  = CB'(d);
    tick();
    wr = 1'b0;
  endtask

  // Commit from IDLE at cycle 0; done must arrive at cycle NTAPS+FC+1 = 21.
  task automatic commit_wait(input string tag);
    int n;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check_eq({tag, " done cycle"}, n, 21);
  endtask

  initial begin
    // Reset release and defaults
    apply_reset();
    check_eq("t1 slot7", slot(7), 10342);
    check_eq("t1 slot0", slot(0), 23);
    check_release("t1");
    model = defs;
    check_bank("t1 bank");

    // Single write then commit: ce walk, slot update timing, blanking window
    write_shadow(3, -1000);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      check_eq($sformatf("t2 ce c%0d", c), int'(ce), (c <= 8) ? (1 << (c - 1)) : 0);
      if (c <= 20) begin
        check_eq($sformatf("t2 valid c%0d", c), int'(valid), 0);
        check_eq($sformatf("t2 busy c%0d", c), int'(busy), 1);
      end
      if (c == 4) check_eq("t2 slot3 old@4", slot(3), 526);
      if (c == 5) check_eq("t2 slot3 new@5", slot(3), -1000);
      if (c == 21) begin
        check_eq("t2 valid@21", int'(valid), 1);
        check_eq("t2 done@21", int'(done), 1);
      end
      if (c < 21) tick();
    end
    model[3] = -1000;
    check_bank("t2 bank");

    // Out-of-range write: error pulse, no aliasing into the bank
    wr      = 1'b1;
    wr_addr = 4'd9;
    wr_dat  = CB'(555);
    tick();
    wr = 1'b0;
    check_eq("t3 wr_err pulse", int'(wr_err), 1);
    tick();
    check_eq("t3 wr_err clear", int'(wr_err), 0);
    commit_wait("t3");
    check_bank("t3 bank");

    // Commit during LOAD sets pending; second LOAD directly after FLUSH
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      if (c <= 40) begin
        check_eq($sformatf("t4 valid c%0d", c), int'(valid), 0);
        check_eq($sformatf("t4 done c%0d", c), int'(done), 0);
      end
      if (c == 21) begin
        check_eq("t4 ce@21", int'(ce), 1);
        check_eq("t4 slot0 old@21", slot(0), 23);
      end
      if (c == 22) check_eq("t4 slot0 new@22", slot(0), 77);
      if (c == 41) begin
        check_eq("t4 valid@41", int'(valid), 1);
        check_eq("t4 done@41", int'(done), 1);
      end
      if (c == 4) begin
        wr      = 1'b1;
        wr_addr = 4'd0;
        wr_dat  = CB'(77);
        commit  = 1'b1;
      end
      if (c < 41) begin
        tick();
        wr     = 1'b0;
        commit = 1'b0;
      end
    end
    model[0] = 77;
    check_bank("t4 bank");

    // Write to the slot being copied in the same cycle is deferred to the next commit
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int c = 1; c < 21; c++) begin
      if (c == 3) begin
        wr      = 1'b1;
        wr_addr = 4'd2;
        wr_dat  = CB'(400);
      end
      if (c == 4) check_eq("t5 slot2 kept@4", slot(2), -263);
      tick();
      wr = 1'b0;
    end
    check_eq("t5 done@21", int'(done), 1);
    check_eq("t5 slot2 kept", slot(2), -263);
    commit_wait("t5 second");
    model[2] = 400;
    check_bank("t5 bank");

    // Reset mid-LOAD restores defaults and restarts blanking
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (4) tick();
    check_eq("t6 ce@5", int'(ce), 16);
    apply_reset();
    model = defs;
    check_bank("t6 bank");
    check_release("t6");
    commit_wait("t6 reload");
    check_bank("t6 shadow defaults");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
